// File: rtl/sram_axi_bridge_pkg.sv
// Shared encodings and AXI constants for the SRAM-to-AXI bridge.
// Holds the FSM state types, the ARID/AWID assignments and the single-beat burst settings.
package sram_axi_bridge_pkg;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_VALID = 1'b1
  } ar_state_e;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_SEND  = 2'd1,
    W_BRESP = 2'd2,
    W_DONE  = 2'd3
  } w_state_e;

  localparam logic [3:0] INST_ID   = 4'd0;
  localparam logic [3:0] DATA_ID   = 4'd1;
  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;

endpackage

// File: rtl/sram_axi_wr_ctrl.sv
// Write engine for the data port: accepts one SRAM write, drives AW and W
// independently, waits for B, then returns a single data_ok pulse.
module sram_axi_wr_ctrl
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        port_idle_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic        idle_o,
  output logic [31:0] awaddr_o,
  output logic [1:0]  size_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  w_state_e    state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  size_q;

  assign idle_o    = (state_q == W_IDLE);
  assign addr_ok_o = idle_o & req_i & port_idle_i;
  assign data_ok_o = (state_q == W_DONE);
  assign awvalid_o = (state_q == W_SEND) & ~aw_done_q;
  assign wvalid_o  = (state_q == W_SEND) & ~w_done_q;
  assign bready_o  = (state_q == W_BRESP);
  assign awaddr_o  = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign size_o    = size_q;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      W_IDLE: if (addr_ok_o) state_d = W_SEND;
      W_SEND: begin
        // AW and W may complete in either order; leave only when both have.
        aw_done_d = aw_done_q | (awvalid_o & awready_i);
        w_done_d  = w_done_q | (wvalid_o & wready_i);
        if (aw_done_d & w_done_d) begin
          state_d   = W_BRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_BRESP: if (bvalid_i) state_d = W_DONE;
      W_DONE:  state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (addr_ok_o) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      wstrb_q <= wstrb_i;
      size_q  <= size_i;
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's instruction and data SRAM-like ports onto one AXI master.
// Reads share a single AR channel (data beats inst); responses are steered by RID.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  ar_state_e   ar_state_q, ar_state_d;
  logic        inst_busy_q, inst_busy_d;
  logic        drd_busy_q, drd_busy_d;
  logic        inst_ok_q, inst_ok_d;
  logic        drd_ok_q, drd_ok_d;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic [31:0] araddr_q;
  logic [1:0]  arsize_q;
  logic [3:0]  arid_q;
  logic        data_rd_acc, inst_rd_acc, r_hs;
  logic        wr_idle, wr_addr_ok, wr_data_ok;
  logic [1:0]  wr_size;
  logic        unused_in;

  assign unused_in = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       rresp, rlast, bid, bresp};

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = AXI_LEN;
  assign arsize  = {1'b0, arsize_q};
  assign arburst = AXI_BURST;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (ar_state_q == AR_VALID);
  assign rready  = ~reset;
  assign r_hs    = rvalid & rready;

  assign awid    = DATA_ID;
  assign wid     = DATA_ID;
  assign awlen   = AXI_LEN;
  assign awsize  = {1'b0, wr_size};
  assign awburst = AXI_BURST;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wlast   = 1'b1;

  assign inst_sram_addr_ok = inst_rd_acc;
  assign inst_sram_data_ok = inst_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_addr_ok = data_rd_acc | wr_addr_ok;
  assign data_sram_data_ok = drd_ok_q | wr_data_ok;
  assign data_sram_rdata   = data_rdata_q;

  always_comb begin
    ar_state_d  = ar_state_q;
    inst_busy_d = inst_busy_q;
    drd_busy_d  = drd_busy_q;
    // A data read waits for any write in flight so it observes the written value.
    data_rd_acc = (ar_state_q == AR_IDLE) & data_sram_req & ~data_sram_wr &
                  ~drd_busy_q & wr_idle;
    inst_rd_acc = (ar_state_q == AR_IDLE) & inst_sram_req & ~inst_busy_q & ~data_rd_acc;
    inst_ok_d   = r_hs & (rid == INST_ID) & inst_busy_q & ~inst_ok_q;
    drd_ok_d    = r_hs & (rid == DATA_ID) & drd_busy_q & ~drd_ok_q;
    unique case (ar_state_q)
      AR_IDLE:  if (data_rd_acc | inst_rd_acc) ar_state_d = AR_VALID;
      AR_VALID: if (arready) ar_state_d = AR_IDLE;
      default:  ar_state_d = AR_IDLE;
    endcase
    if (inst_rd_acc) inst_busy_d = 1'b1;
    else if (inst_ok_q) inst_busy_d = 1'b0;
    if (data_rd_acc) drd_busy_d = 1'b1;
    else if (drd_ok_q) drd_busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state_q   <= AR_IDLE;
      inst_busy_q  <= 1'b0;
      drd_busy_q   <= 1'b0;
      inst_ok_q    <= 1'b0;
      drd_ok_q     <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      ar_state_q  <= ar_state_d;
      inst_busy_q <= inst_busy_d;
      drd_busy_q  <= drd_busy_d;
      inst_ok_q   <= inst_ok_d;
      drd_ok_q    <= drd_ok_d;
      if (inst_ok_d) inst_rdata_q <= rdata;
      if (drd_ok_d)  data_rdata_q <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (data_rd_acc) begin
      araddr_q <= data_sram_addr;
      arsize_q <= data_sram_size;
      arid_q   <= DATA_ID;
    end else if (inst_rd_acc) begin
      araddr_q <= inst_sram_addr;
      arsize_q <= inst_sram_size;
      arid_q   <= INST_ID;
    end
  end

  sram_axi_wr_ctrl u_wr_ctrl (
    .clk         (clk),
    .reset       (reset),
    .req_i       (data_sram_req & data_sram_wr),
    .port_idle_i (~drd_busy_q),
    .size_i      (data_sram_size),
    .addr_i      (data_sram_addr),
    .wdata_i     (data_sram_wdata),
    .wstrb_i     (data_sram_wstrb),
    .addr_ok_o   (wr_addr_ok),
    .data_ok_o   (wr_data_ok),
    .idle_o      (wr_idle),
    .awaddr_o    (awaddr),
    .size_o      (wr_size),
    .awvalid_o   (awvalid),
    .awready_i   (awready),
    .wdata_o     (wdata),
    .wstrb_o     (wstrb),
    .wvalid_o    (wvalid),
    .wready_i    (wready),
    .bvalid_i    (bvalid),
    .bready_o    (bready)
  );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the AXI slave side is driven by hand
// and every expected value is a hand-computed constant.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_req(input bit is_data, input logic [31:0] a);
    if (is_data) begin
      data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = a;
    end else begin
      inst_sram_req = 1'b1; inst_sram_addr = a;
    end
    #1;
    check_val("rd_addr_ok", is_data ? data_sram_addr_ok : inst_sram_addr_ok, 1);
    tick();
    data_sram_req = 1'b0; inst_sram_req = 1'b0;
    check_val("rd_arvalid", arvalid, 1);
    check_val("rd_arid", arid, is_data ? 32'd1 : 32'd0);
    check_val("rd_araddr", araddr, a);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_val("rd_arvalid_drop", arvalid, 0);
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
    rvalid = 1'b1; rid = id; rdata = d;
    tick();
    rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    repeat (3) tick();

    // reset state
    check_val("rst_arvalid", arvalid, 0);
    check_val("rst_awvalid", awvalid, 0);
    check_val("rst_wvalid", wvalid, 0);
    check_val("rst_bready", bready, 0);
    check_val("rst_rready", rready, 0);
    check_val("rst_inst_ok", inst_sram_data_ok, 0);
    check_val("rst_data_ok", data_sram_data_ok, 0);
    check_val("rst_inst_rdata", inst_sram_rdata, 0);
    check_val("rst_data_rdata", data_sram_rdata, 0);
    reset = 1'b0;
    tick();
    check_val("rready_up", rready, 1);

    // single inst read
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000000;
    #1;
    check_val("i_addr_ok", inst_sram_addr_ok, 1);
    tick();
    inst_sram_req = 1'b0;
    check_val("i_arvalid", arvalid, 1);
    check_val("i_araddr", araddr, 32'h1C000000);
    check_val("i_arid", arid, 0);
    check_val("i_arsize", arsize, 3'd2);
    check_val("i_arlen", arlen, 0);
    check_val("i_arburst", arburst, 2'b01);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_val("i_arvalid_drop", arvalid, 0);
    inst_sram_req = 1'b1;
    #1;
    check_val("i_busy_block", inst_sram_addr_ok, 0);
    inst_sram_req = 1'b0;
    tick();
    r_beat(4'd0, 32'h02800C0C);
    check_val("i_data_ok", inst_sram_data_ok, 1);
    check_val("i_rdata", inst_sram_rdata, 32'h02800C0C);
    check_val("i_no_data_ok", data_sram_data_ok, 0);
    tick();
    check_val("i_data_ok_pulse", inst_sram_data_ok, 0);

    // simultaneous inst/data reads; data wins, responses returned inst-first
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000004;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h00002000;
    #1;
    check_val("arb_data_ok", data_sram_addr_ok, 1);
    check_val("arb_inst_wait", inst_sram_addr_ok, 0);
    tick();
    data_sram_req = 1'b0;
    check_val("arb_arid_d", arid, 1);
    check_val("arb_araddr_d", araddr, 32'h00002000);
    check_val("arb_inst_held", inst_sram_addr_ok, 0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    check_val("arb_inst_retry", inst_sram_addr_ok, 1);
    tick();
    inst_sram_req = 1'b0;
    check_val("arb_arid_i", arid, 0);
    check_val("arb_araddr_i", araddr, 32'h1C000004);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    r_beat(4'd0, 32'h11112222);
    check_val("arb_i_ok", inst_sram_data_ok, 1);
    check_val("arb_i_rdata", inst_sram_rdata, 32'h11112222);
    check_val("arb_d_not_ok", data_sram_data_ok, 0);
    r_beat(4'd1, 32'h33334444);
    check_val("arb_d_ok", data_sram_data_ok, 1);
    check_val("arb_d_rdata", data_sram_rdata, 32'h33334444);
    check_val("arb_i_not_ok", inst_sram_data_ok, 0);
    tick();

    // inst issued first, data response returns first
    rd_req(1'b0, 32'h1C000010);
    rd_req(1'b1, 32'h00003000);
    r_beat(4'd1, 32'hAAAA5555);
    check_val("ooo_d_ok", data_sram_data_ok, 1);
    check_val("ooo_i_quiet", inst_sram_data_ok, 0);
    check_val("ooo_d_rdata", data_sram_rdata, 32'hAAAA5555);
    r_beat(4'd0, 32'h5555AAAA);
    check_val("ooo_i_ok", inst_sram_data_ok, 1);
    check_val("ooo_i_rdata", inst_sram_rdata, 32'h5555AAAA);
    check_val("ooo_d_kept", data_sram_rdata, 32'hAAAA5555);
    tick();

    // write with AW before W, then read-after-write
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h00001000;
    data_sram_wdata = 32'hDEADBEEF; data_sram_wstrb = 4'hF;
    #1;
    check_val("w_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 1'b0;
    check_val("w_awvalid", awvalid, 1);
    check_val("w_wvalid", wvalid, 1);
    check_val("w_awaddr", awaddr, 32'h00001000);
    check_val("w_wdata", wdata, 32'hDEADBEEF);
    check_val("w_wstrb", wstrb, 4'hF);
    check_val("w_awid", awid, 1);
    check_val("w_wid", wid, 1);
    check_val("w_wlast", wlast, 1);
    check_val("w_awsize", awsize, 3'd2);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    check_val("w_aw_dropped", awvalid, 0);
    check_val("w_w_held", wvalid, 1);
    data_sram_req = 1'b1; data_sram_wr = 1'b0;
    #1;
    check_val("raw_block_send", data_sram_addr_ok, 0);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    check_val("w_w_dropped", wvalid, 0);
    check_val("w_bready", bready, 1);
    check_val("raw_block_bresp", data_sram_addr_ok, 0);
    check_val("w_no_early_ok", data_sram_data_ok, 0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check_val("w_data_ok", data_sram_data_ok, 1);
    check_val("raw_block_done", data_sram_addr_ok, 0);
    tick();
    check_val("w_data_ok_pulse", data_sram_data_ok, 0);
    check_val("raw_accept", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 1'b0;
    check_val("raw_araddr", araddr, 32'h00001000);
    check_val("raw_arid", arid, 1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    r_beat(4'd1, 32'hDEADBEEF);
    check_val("raw_ok", data_sram_data_ok, 1);
    check_val("raw_rdata", data_sram_rdata, 32'hDEADBEEF);
    tick();

    // reset while a write waits for B and an inst read is outstanding
    rd_req(1'b0, 32'h1C000020);
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h00001004;
    data_sram_wdata = 32'h12345678;
    tick();
    data_sram_req = 1'b0;
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    check_val("rst_mid_bready", bready, 1);
    reset = 1'b1;
    tick();
    check_val("rstm_awvalid", awvalid, 0);
    check_val("rstm_wvalid", wvalid, 0);
    check_val("rstm_bready", bready, 0);
    check_val("rstm_data_ok", data_sram_data_ok, 0);
    reset = 1'b0;
    bvalid = 1'b1; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0BAD0BAD;
    tick();
    bvalid = 1'b0; rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("stale_d_ok", data_sram_data_ok, 0);
      check_val("stale_i_ok", inst_sram_data_ok, 0);
      check_val("stale_i_rdata", inst_sram_rdata, 0);
      tick();
    end
    data_sram_req = 1'b1; data_sram_wr = 1'b1;
    #1;
    check_val("post_rst_w_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 1'b0;
    check_val("post_rst_awaddr", awaddr, 32'h00001004);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check_val("post_rst_data_ok", data_sram_data_ok, 1);
    tick();
    check_val("post_rst_pulse", data_sram_data_ok, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
